// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
//   state_t    : sequencer FSM states
//   pc_sel_t   : next-PC source select driven by the FSM into pc_target_mux
//   PC_INCR    : sequential fetch increment (one 32-bit instruction word)
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        BUBBLE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD     = 2'd0,
        SEL_ADVANCE  = 2'd1,
        SEL_REDIRECT = 2'd2
    } pc_sel_t;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC source selection for the fetch sequencer.
// Ports:
//   pc              in   current fetch address
//   jump/jump_target, branch_taken/branch_target  in  redirect requests
//   sel             in   hold / advance / redirect select from the FSM
//   next_pc         out  value to load into the PC register
//   pc_plus4        out  pc + 4, wrapping modulo 2^32
//   redirect        out  jump | branch_taken
//   target_misalign out  selected redirect target has nonzero bits [1:0]
module pc_target_mux
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  pc_sel_t     sel,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        target_misalign
);

    logic [31:0] target;

    // Jump wins over a simultaneously resolved branch.
    assign target          = jump ? jump_target : branch_target;
    assign redirect        = jump | branch_taken;
    assign target_misalign = |target[1:0];
    assign pc_plus4        = pc + PC_INCR;

    always_comb begin
        next_pc = pc;
        unique case (sel)
            SEL_ADVANCE:  next_pc = pc_plus4;
            SEL_REDIRECT: next_pc = {target[31:2], 2'b00};
            default:      next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: walks the fetch address by 4, holds on
// stall or memory wait, and redirects on jump/branch with a one-cycle
// bubble that kills the wrong-path IF/ID entry.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   stall               hazard-unit hold request
//   imem_ready          instruction memory returns the word at pc_out
//   branch_taken/target resolved branch redirect
//   jump/jump_target    jump redirect (priority over branch)
//   pc_out              current fetch address (PC register)
//   pc_plus4            pc_out + 4, combinational
//   if_valid            fetched word is captured into IF/ID this cycle
//   flush               IF/ID kill, high during the redirect bubble
//   misalign            one-cycle pulse after a redirect to an unaligned target
//   fetch_count         number of accepted fetches
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    state_t      state, next_state;
    pc_sel_t     sel;
    logic [31:0] next_pc;
    logic        redirect;
    logic        target_misalign;
    logic        take_redirect;

    pc_target_mux u_mux (
        .pc              (pc_out),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .sel             (sel),
        .next_pc         (next_pc),
        .pc_plus4        (pc_plus4),
        .redirect        (redirect),
        .target_misalign (target_misalign)
    );

    always_comb begin
        next_state    = state;
        sel           = SEL_HOLD;
        if_valid      = 1'b0;
        take_redirect = 1'b0;
        unique case (state)
            IDLE: begin
                // Redirects are ignored until the first fetch is issued.
                next_state = FETCH;
            end
            FETCH, HOLD: begin
                if (redirect) begin
                    sel           = SEL_REDIRECT;
                    take_redirect = 1'b1;
                    next_state    = BUBBLE;
                end else if (stall || !imem_ready) begin
                    next_state = HOLD;
                end else begin
                    sel        = SEL_ADVANCE;
                    if_valid   = 1'b1;
                    next_state = FETCH;
                end
            end
            BUBBLE: begin
                // A back-to-back redirect restarts the bubble at the new target.
                if (redirect) begin
                    sel           = SEL_REDIRECT;
                    take_redirect = 1'b1;
                    next_state    = BUBBLE;
                end else begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc_out      <= RESET_PC;
            flush       <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state    <= next_state;
            pc_out   <= next_pc;
            flush    <= (next_state == BUBBLE);
            misalign <= take_redirect & target_misalign;
            if (if_valid)
                fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a driver issues one input vector
// per cycle, predicts that cycle's outputs from a behavioural model and
// queues them; a monitor on the falling edge pops and compares.
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, imem_ready, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, pc_plus4, fetch_count;
    logic        if_valid, flush, misalign;

    pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .if_valid      (if_valid),
        .flush         (flush),
        .misalign      (misalign),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        ifv;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    // Behavioural model: "started" is false only in the cycle after reset,
    // "in_bubble" marks the cycle following an accepted redirect.
    bit          m_known   = 0;
    bit          m_started = 0;
    bit          m_bubble  = 0;
    bit          m_mis     = 0;
    logic [31:0] m_pc      = '0;
    logic [31:0] m_cnt     = '0;

    task automatic chk(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Apply the inputs for the coming edge, queue the outputs the DUT must
    // show in this cycle, then advance the model past that edge.
    task automatic model_apply(input bit r, input bit s, input bit rdy,
                               input bit b, input logic [31:0] btg,
                               input bit j, input logic [31:0] jtg);
        exp_t        e;
        bit          redir;
        bit          fetch_ok;
        logic [31:0] tgt;
        rst = r; stall = s; imem_ready = rdy;
        branch_taken = b; branch_target = btg;
        jump = j; jump_target = jtg;
        redir    = j | b;
        tgt      = j ? jtg : btg;
        fetch_ok = m_started && !m_bubble && rdy && !s && !redir;
        if (m_known) begin
            e.cyc = cyc_no;
            e.pc  = m_pc;
            e.pc4 = m_pc + 32'd4;
            e.cnt = m_cnt;
            e.ifv = fetch_ok;
            e.fl  = m_bubble;
            e.mis = m_mis;
            q.push_back(e);
        end
        if (r) begin
            m_known = 1; m_started = 0; m_bubble = 0; m_mis = 0;
            m_pc = RPC; m_cnt = '0;
        end else if (!m_started) begin
            m_started = 1;
            m_mis     = 0;
        end else begin
            m_mis = 0;
            if (redir) begin
                m_pc     = tgt & 32'hFFFF_FFFC;
                m_bubble = 1;
                m_mis    = (tgt % 4) != 0;
            end else if (m_bubble) begin
                m_bubble = 0;
            end else if (fetch_ok) begin
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit rdy,
                         input bit b, input logic [31:0] btg,
                         input bit j, input logic [31:0] jtg);
        @(posedge clk);
        #1;
        cyc_no++;
        model_apply(r, s, rdy, b, btg, j, jtg);
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, '0, 0, '0);
    endtask

    // Monitor
    exp_t e_mon;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e_mon = q.pop_front();
            chk("pc_out",      e_mon.cyc, pc_out,             e_mon.pc);
            chk("pc_plus4",    e_mon.cyc, pc_plus4,           e_mon.pc4);
            chk("fetch_count", e_mon.cyc, fetch_count,        e_mon.cnt);
            chk("if_valid",    e_mon.cyc, {31'd0, if_valid},  {31'd0, e_mon.ifv});
            chk("flush",       e_mon.cyc, {31'd0, flush},     {31'd0, e_mon.fl});
            chk("misalign",    e_mon.cyc, {31'd0, misalign},  {31'd0, e_mon.mis});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bt, jt;
        bit          r, s, rdy, b, j;
        int          guard;

        // Reset asserted before the first edge.
        model_apply(1, 0, 1, 0, '0, 0, '0);

        // Idle cycle, then 0,4,8,12 fetches.
        adv(5);                                   // reaches 0x10
        // Three stalled cycles at 0x10, then release.
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, '0, 0, '0);
        adv(1);
        // Advance to 0x20, then branch to 0x100.
        guard = 0;
        while (m_pc != 32'h20 && guard < 20) begin adv(1); guard++; end
        chk("reach_0x20", cyc_no, m_pc, 32'h20);
        cycle(0, 0, 1, 1, 32'h100, 0, '0);
        adv(3);
        // Jump has priority over branch; unaligned jump target.
        cycle(0, 0, 1, 1, 32'h300, 1, 32'h200);
        adv(2);
        cycle(0, 0, 1, 0, '0, 1, 32'h203);
        adv(2);
        // Wrap from 0xFFFF_FFFC to 0.
        cycle(0, 0, 1, 0, '0, 1, 32'hFFFF_FFFC);
        adv(3);
        // Memory wait then back-to-back redirects.
        cycle(0, 0, 0, 0, '0, 0, '0);
        cycle(0, 1, 0, 0, '0, 0, '0);
        cycle(0, 0, 1, 1, 32'h41, 0, '0);
        cycle(0, 0, 1, 0, '0, 1, 32'h80);
        adv(2);
        // Reset during bubble with redirect high.
        cycle(0, 0, 1, 1, 32'h400, 0, '0);
        cycle(1, 1, 1, 1, 32'h500, 1, 32'h600);
        // Redirect in IDLE is ignored.
        cycle(0, 0, 1, 0, '0, 1, 32'h700);
        adv(2);
        // Reset while holding.
        cycle(0, 1, 1, 0, '0, 0, '0);
        cycle(1, 1, 1, 0, '0, 0, '0);
        adv(3);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 15);
            rdy = ($urandom_range(0, 99) >= 15);
            b   = ($urandom_range(0, 99) < 10);
            j   = ($urandom_range(0, 99) < 6);
            bt  = $urandom;
            jt  = $urandom;
            if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) jt = 32'hFFFF_FFF0;
            cycle(r, s, rdy, b, bt, j, jt);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drain", cyc_no, q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
